// File: rtl/lapido_pkg.sv
// Shared lapido definitions: architectural flag bit positions, branch condition
// codes and the condition evaluation used by the result stage.
package lapido_pkg;

   localparam int FLAGS_W      = 6;
   localparam int FLAG_ZERO    = 0;
   localparam int FLAG_TRUE    = 1;
   localparam int FLAG_NEG     = 2;
   localparam int FLAG_OVF     = 3;
   localparam int FLAG_NEGZERO = 4;
   localparam int FLAG_CARRY   = 5;

   typedef enum logic [2:0] {
      COND_ZERO    = 3'd0,
      COND_TRUE    = 3'd1,
      COND_NEG     = 3'd2,
      COND_OVF     = 3'd3,
      COND_NEGZERO = 3'd4,
      COND_CARRY   = 3'd5,
      COND_ALWAYS  = 3'd6,
      COND_NEVER   = 3'd7
   } cond_sel_e;

   function automatic logic cond_eval(input logic [FLAGS_W-1:0] flags,
                                      input logic [2:0]         sel,
                                      input logic               inv);
      logic selBit;
      case (cond_sel_e'(sel))
         COND_ZERO:    selBit = flags[FLAG_ZERO];
         COND_TRUE:    selBit = flags[FLAG_TRUE];
         COND_NEG:     selBit = flags[FLAG_NEG];
         COND_OVF:     selBit = flags[FLAG_OVF];
         COND_NEGZERO: selBit = flags[FLAG_NEGZERO];
         COND_CARRY:   selBit = flags[FLAG_CARRY];
         COND_ALWAYS:  selBit = 1'b1;
         default:      selBit = 1'b0;
      endcase
      return selBit ^ inv;
   endfunction

endpackage

// File: rtl/result_fifo2.sv
// Two-entry in-order result buffer with 1-bit wrapping pointers and a
// synchronous flush that empties it without touching stored data.
module result_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         wptr_q, wptr_d;
   logic         rptr_q, rptr_d;
   logic [1:0]   count_q, count_d;

   always_comb begin
      mem_d[0] = mem_q[0];
      mem_d[1] = mem_q[1];
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wptr_d  = 1'b0;
         rptr_d  = 1'b0;
         count_d = 2'd0;
      end else begin
         if (push_i) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d        = ~wptr_q;
         end
         if (pop_i) begin
            rptr_d = ~rptr_q;
         end
         count_d = count_q + 2'(push_i) - 2'(pop_i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers results for writeback, holds the architectural
// flags and evaluates the branch condition from the registered flags.
module alu_result_stage
   import lapido_pkg::*;
#(
   parameter int RD_W  = 5,
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_res,
   input  logic [FLAGS_W-1:0] in_flags,
   input  logic [RD_W-1:0]    in_rd,
   input  logic               in_rf_we,
   input  logic               in_fl_we,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_res,
   output logic [RD_W-1:0]    out_rd,
   output logic               out_rf_we,
   output logic [FLAGS_W-1:0] flags_q,
   input  logic [2:0]         cond_sel,
   input  logic               cond_inv,
   output logic               cond_met
);

   localparam int ENTRY_W = 32 + RD_W + 1;

   logic [1:0]         count;
   logic               accept;
   logic               pop;
   logic [ENTRY_W-1:0] head;
   logic [FLAGS_W-1:0] flags_d;

   // Flush outranks everything: it blocks the accept and cancels any pop.
   assign in_ready  = (count != 2'(DEPTH)) && !flush;
   assign accept    = in_valid && in_ready;
   assign out_valid = (count != 2'd0);
   assign pop       = out_valid && out_ready && !flush;

   result_fifo2 #(
      .W(ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .push_i  (accept),
      .pop_i   (pop),
      .wdata_i ({in_rf_we, in_rd, in_res}),
      .rdata_o (head),
      .count_o (count)
   );

   assign {out_rf_we, out_rd, out_res} = head;

   always_comb begin
      flags_d = flags_q;
      if (accept && in_fl_we) begin
         flags_d = in_flags;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign cond_met = cond_eval(flags_q, cond_sel, cond_inv);

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed vector table, async reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_alu_result_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_res;
   logic [5:0]  in_flags;
   logic [4:0]  in_rd;
   logic        in_rf_we;
   logic        in_fl_we;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_res;
   logic [4:0]  out_rd;
   logic        out_rf_we;
   logic [5:0]  flags_q;
   logic [2:0]  cond_sel;
   logic        cond_inv;
   logic        cond_met;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        iv;
      logic [31:0] res;
      logic [5:0]  fl;
      logic [4:0]  rd;
      logic        rfwe;
      logic        flwe;
      logic        fls;
      logic        ordy;
      logic [2:0]  sel;
      logic        inv;
      logic        eReady;
      logic        eValid;
      logic [31:0] eRes;
      logic [4:0]  eRd;
      logic        eRfwe;
      logic [5:0]  eFlags;
      logic        eCond;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        rfwe;
   } ent_t;

   vec_t vecs [16];
   ent_t modelQ [$];
   logic [5:0] modelFlags;

   alu_result_stage #(.RD_W(5), .DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_res    (in_res),
      .in_flags  (in_flags),
      .in_rd     (in_rd),
      .in_rf_we  (in_rf_we),
      .in_fl_we  (in_fl_we),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_rd    (out_rd),
      .out_rf_we (out_rf_we),
      .flags_q   (flags_q),
      .cond_sel  (cond_sel),
      .cond_inv  (cond_inv),
      .cond_met  (cond_met)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic iv, logic [31:0] res, logic [5:0] fl, logic [4:0] rd,
                               logic rfwe, logic flwe, logic fls, logic ordy,
                               logic [2:0] sel, logic inv, logic eReady, logic eValid,
                               logic [31:0] eRes, logic [4:0] eRd, logic eRfwe,
                               logic [5:0] eFlags, logic eCond);
      vec_t v;
      v.iv = iv; v.res = res; v.fl = fl; v.rd = rd; v.rfwe = rfwe; v.flwe = flwe;
      v.fls = fls; v.ordy = ordy; v.sel = sel; v.inv = inv; v.eReady = eReady;
      v.eValid = eValid; v.eRes = eRes; v.eRd = eRd; v.eRfwe = eRfwe;
      v.eFlags = eFlags; v.eCond = eCond;
      return v;
   endfunction

   // Reference branch condition straight from the flag/code definitions.
   function automatic logic expCond(logic [5:0] fl, logic [2:0] sel, logic inv);
      logic b;
      if (sel < 3'd6) b = fl[sel];
      else            b = (sel == 3'd6);
      return b ^ inv;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      in_valid  = v.iv;
      in_res    = v.res;
      in_flags  = v.fl;
      in_rd     = v.rd;
      in_rf_we  = v.rfwe;
      in_fl_we  = v.flwe;
      flush     = v.fls;
      out_ready = v.ordy;
      cond_sel  = v.sel;
      cond_inv  = v.inv;
   endtask

   task automatic modelCycle();
      logic expReady;
      logic acc;
      logic pop;
      ent_t e;
      expReady = (modelQ.size() != 2) && !flush;
      checkOutput("rnd_in_ready", in_ready, expReady);
      checkOutput("rnd_out_valid", out_valid, modelQ.size() != 0);
      if (modelQ.size() != 0) begin
         checkOutput("rnd_out_res", out_res, modelQ[0].res);
         checkOutput("rnd_out_rd", out_rd, modelQ[0].rd);
         checkOutput("rnd_out_rf_we", out_rf_we, modelQ[0].rfwe);
      end
      checkOutput("rnd_flags", flags_q, modelFlags);
      checkOutput("rnd_cond", cond_met, expCond(modelFlags, cond_sel, cond_inv));
      acc = in_valid && expReady;
      pop = (modelQ.size() != 0) && out_ready && !flush;
      if (flush) begin
         modelQ.delete();
      end else begin
         if (pop) void'(modelQ.pop_front());
         if (acc) begin
            e.res = in_res; e.rd = in_rd; e.rfwe = in_rf_we;
            modelQ.push_back(e);
         end
      end
      if (acc && in_fl_we) modelFlags = in_flags;
   endtask

   initial begin
      vecs[0]  = mk(1, 32'h5, 6'b000010, 3, 1, 1, 0, 0, 1, 0,  1, 0, 0, 0, 0, 6'b000000, 0);
      vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,              1, 1, 32'h5, 3, 1, 6'b000010, 1);
      vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,              1, 1, 32'h5, 3, 1, 6'b000010, 1);
      vecs[3]  = mk(1, 32'hA, 0, 1, 1, 0, 0, 0, 7, 1,          1, 0, 0, 0, 0, 6'b000010, 1);
      vecs[4]  = mk(1, 32'hB, 0, 2, 1, 0, 0, 0, 5, 0,          1, 1, 32'hA, 1, 1, 6'b000010, 0);
      vecs[5]  = mk(1, 32'hC, 0, 4, 0, 0, 0, 0, 6, 0,          0, 1, 32'hA, 1, 1, 6'b000010, 1);
      vecs[6]  = mk(1, 32'hC, 0, 4, 0, 0, 0, 1, 6, 1,          0, 1, 32'hA, 1, 1, 6'b000010, 0);
      vecs[7]  = mk(1, 32'hC, 0, 4, 0, 0, 0, 1, 1, 1,          1, 1, 32'hB, 2, 1, 6'b000010, 0);
      vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,              1, 1, 32'hC, 4, 0, 6'b000010, 0);
      vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,              1, 0, 0, 0, 0, 6'b000010, 1);
      vecs[10] = mk(1, 32'hD, 0, 5, 1, 0, 0, 0, 2, 0,          1, 0, 0, 0, 0, 6'b000010, 0);
      vecs[11] = mk(1, 32'hE, 0, 6, 1, 0, 0, 0, 2, 0,          1, 1, 32'hD, 5, 1, 6'b000010, 0);
      vecs[12] = mk(1, 32'hF, 6'b111111, 7, 1, 1, 1, 1, 3, 0,  0, 1, 32'hD, 5, 1, 6'b000010, 0);
      vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0,              1, 0, 0, 0, 0, 6'b000010, 0);
      vecs[14] = mk(1, 32'h1234_5678, 6'b100001, 7, 1, 1, 0, 0, 5, 0, 1, 0, 0, 0, 0, 6'b000010, 0);
      vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0,              1, 1, 32'h1234_5678, 7, 1, 6'b100001, 1);

      rst_n = 1'b0;
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      checkOutput("reset_out_valid", out_valid, 1'b0);
      checkOutput("reset_in_ready", in_ready, 1'b1);
      checkOutput("reset_out_res", out_res, 32'h0);
      checkOutput("reset_out_rd", out_rd, 5'd0);
      checkOutput("reset_out_rf_we", out_rf_we, 1'b0);
      checkOutput("reset_flags", flags_q, 6'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].eReady);
         checkOutput($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].eValid);
         if (vecs[i].eValid) begin
            checkOutput($sformatf("vec%0d_out_res", i), out_res, vecs[i].eRes);
            checkOutput($sformatf("vec%0d_out_rd", i), out_rd, vecs[i].eRd);
            checkOutput($sformatf("vec%0d_out_rf_we", i), out_rf_we, vecs[i].eRfwe);
         end
         checkOutput($sformatf("vec%0d_flags", i), flags_q, vecs[i].eFlags);
         checkOutput($sformatf("vec%0d_cond", i), cond_met, vecs[i].eCond);
         @(posedge clk); #1;
      end

      // Head is 0x12345678 (count 1); fill to 2, then pull reset mid-cycle.
      applyStimulus(mk(1, 32'hCAFE, 6'b010101, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1;
      checkOutput("full_in_ready", in_ready, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async_out_valid", out_valid, 1'b0);
      checkOutput("async_flags", flags_q, 6'd0);
      checkOutput("async_out_res", out_res, 32'h0);
      checkOutput("async_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      modelQ.delete();
      modelFlags = 6'd0;
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_res    = $urandom;
         in_flags  = 6'($urandom);
         in_rd     = 5'($urandom);
         in_rf_we  = 1'($urandom);
         in_fl_we  = ($urandom_range(0, 2) == 0);
         flush     = ($urandom_range(0, 19) == 0);
         out_ready = 1'($urandom);
         cond_sel  = 3'($urandom);
         cond_inv  = 1'($urandom);
         #1;
         modelCycle();
         @(posedge clk); #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
